rom_reader: RTL and testbench
=============================

# rom_reader

Upstream sequencer for the `memory` ROM block. It accepts a burst request (start address, word count) and drives the ROM's `read`/`address` inputs, one address per cycle. It captures `d_out` after the fixed ROM read latency and delivers the words in order on a valid/ready stream. A small output FIFO plus credit counting means back-pressure never drops a word.

## Interface
Parameters:
- `AW`, 4, ROM address width
- `DW`, 4, ROM data width
- `RD_LAT`, 1, cycles after the issue cycle in which `mem_dout` is valid
- `FIFO_DEPTH`, 4, output FIFO entries (power of two, ≥ RD_LAT+3)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  burst request pulse, sampled only in IDLE
- `start_addr`  in  AW  first ROM address of burst
- `count`  in  AW+1  words in burst, 0..2^AW
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle pulse at burst completion
- `mem_read`  out  1  to ROM `read`; high in each issue cycle
- `mem_addr`  out  AW  to ROM `address`
- `mem_dout`  in  DW  from ROM `d_out`
- `out_valid`  out  1  stream data valid
- `out_data`  out  DW  stream data
- `out_ready`  in  1  stream consumer ready

## Operation
- The FSM has three states.
  - IDLE → RUN on `start` with `count`≠0. This latches `start_addr` into `cur_addr` and `count` into `remaining`.
  - `start` with `count`=0 pulses `done` next cycle and stays in IDLE.
  - RUN → DRAIN when the last address has been issued (`remaining` reaches 0).
  - DRAIN → IDLE when in-flight=0 and FIFO empty. The `done` pulse coincides with IDLE entry.
- `busy`=1 in RUN and DRAIN. `start` is ignored while busy, with no queueing.
- Issue rule, evaluated in RUN each cycle: issue iff `remaining`>0 and `fifo_count` + `inflight` < FIFO_DEPTH.
  - The check uses registered counts only and does not credit a same-cycle pop.
  - On issue: `cur_addr` ← `cur_addr`+1, `remaining` ← `remaining`−1.
- Address arithmetic is modulo 2^AW. For example, `start_addr`=14 with `count`=4 reads 14, 15, 0, 1.
- Capture: an RD_LAT-deep valid shift register tracks issues. When its tail is set, `mem_dout` is pushed into the FIFO.
- `inflight` is the number of issued, not-yet-captured words.
- FIFO push never meets a full FIFO; the credit rule guarantees this. A push into a full FIFO is an assertion failure in the bench.
- `out_data` is the FIFO head. A pop occurs on `out_valid && out_ready`, and push and pop may happen in the same cycle.
- Words leave in issue order, exactly `count` words per burst.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_read`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0. The FSM returns to IDLE and the FIFO, counters and shift register are cleared.
- Reset mid-burst: in-flight and buffered words are discarded, and no `done` pulse is produced.
- `mem_read`/`mem_addr` are registered. If `start` is sampled at edge t, the first issue is visible in cycle t+1.
- Issue in cycle c: ROM samples at the end of c, the word is captured at the end of c+RD_LAT, and `out_valid` is seen in c+RD_LAT+1.
- Latency from start edge t to first `out_valid`: cycle t+2+RD_LAT (t+3 at defaults).
- Throughput: with `out_ready` held high at default parameters, one word per cycle with no issue gaps.
- When `mem_read`=0, `mem_addr` holds its last value.
- Back-pressure: issuing halts within one cycle of credits running out and resumes the cycle after a pop frees a credit.
- `done` asserts the cycle after the final word is popped.

## Structure
- The shared package `rom_rd_pkg` holds default `AW`/`DW` and the FSM state enum (IDLE, RUN, DRAIN).
- Sub-module `rom_rd_fifo` is a synchronous FIFO with push/pop, registered head, `count`, `full` and `empty`, and the same `clk`/`rst_n`.
- Top level: FSM, address/remaining counters, latency shift register, credit logic.

## Test plan
- Basic burst: start_addr=0, count=16, out_ready=1. Expect 16 words matching ROM contents 0..15 on consecutive cycles, first `out_valid` at t+3, and `done` one cycle after the last pop.
- Wrap-around: start_addr=14, count=4. Expect `mem_addr` sequence 14, 15, 0, 1 and data in that order.
- Back-pressure: count=8, out_ready low for 10 cycles mid-burst. Expect at most 4 words buffered, no loss or duplication, and the correct order on resume.
- Zero/ignored starts: count=0 gives `done` next cycle, `busy` stays 0, and `mem_read` is never asserted. A second `start` while busy is ignored and produces exactly one burst.
- Reset mid-burst: deassert `rst_n` for one cycle after 3 words.
  - Expect all outputs at reset values on the next cycle, `out_valid`=0, and no `done`.
  - A new burst afterwards behaves like the basic case.

Source files
------------

// File: rtl/rom_rd_pkg.sv
// Shared definitions for the ROM burst reader: default widths and FSM states.
package rom_rd_pkg;

  localparam int unsigned DefAw = 4;
  localparam int unsigned DefDw = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } rd_state_e;

endpackage

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO: head word always presented on rdata, occupancy on count.
module rom_rd_fifo #(
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Status flags, guarded push/pop and head presentation.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && !full;
    rdata   = mem_q[rd_ptr_q];
    count   = count_q;
  end

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rom_reader.sv
// Burst sequencer for a fixed-latency ROM. Issues one address per cycle, captures
// the returned words after RD_LAT cycles and streams them out through a FIFO.
// Issue credits (FIFO occupancy + words in flight) keep the FIFO from overflowing.
module rom_reader
  import rom_rd_pkg::*;
#(
  parameter int unsigned AW         = DefAw,
  parameter int unsigned DW         = DefDw,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_dout,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  rd_state_e         state_q, state_d;
  logic [AW-1:0]     cur_addr_q, cur_addr_d;
  logic [AW:0]       remaining_q, remaining_d;
  logic              mem_read_q, mem_read_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [CW-1:0]     inflight_q, inflight_d;

  logic              start_ok;
  logic              zero_start;
  logic              credit_ok;
  logic              issue;
  logic              drain_done;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       base_rem;

  logic              push;
  logic              pop;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DW-1:0]     fifo_head;

  rom_rd_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (mem_dout),
    .pop   (pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Start acceptance and the issue rule. An accepted start is treated as latching
  // start_addr/count and evaluating the issue rule in the same cycle, so the first
  // registered mem_read appears right after the start edge. Credits use registered
  // counts only; a pop in this cycle is not credited until the next.
  always_comb begin
    start_ok   = (state_q == StIdle) && start && (count != '0);
    zero_start = (state_q == StIdle) && start && (count == '0);
    credit_ok  = !fifo_full &&
                 (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW + 1)'(FIFO_DEPTH));
    base_addr  = start_ok ? start_addr : cur_addr_q;
    base_rem   = start_ok ? count : remaining_q;
    issue      = (start_ok || (state_q == StRun)) && (base_rem != '0) && credit_ok;
  end

  // Burst is finished once nothing is in flight and the last buffered word leaves now.
  always_comb begin
    drain_done = (inflight_q == '0) &&
                 (fifo_empty || ((fifo_count == CW'(1)) && pop));
  end

  // Address/remaining counters, issue registers, latency tracking and credits.
  always_comb begin
    cur_addr_d  = base_addr;
    remaining_d = base_rem;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = issue;
    if (issue) begin
      mem_addr_d  = base_addr;
      cur_addr_d  = base_addr + AW'(1);
      remaining_d = base_rem - (AW + 1)'(1);
    end
    // vld_q[i] set means an issued word is i+1 cycles past its issue cycle.
    vld_d    = '0;
    vld_d[0] = mem_read_q;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
    end
    inflight_d = inflight_q + CW'(issue) - CW'(push);
    done_d     = zero_start || ((state_q == StDrain) && drain_done);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      done_q      <= 1'b0;
      vld_q       <= '0;
      inflight_q  <= '0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      mem_read_q  <= mem_read_d;
      mem_addr_q  <= mem_addr_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
      inflight_q  <= inflight_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (remaining_q == '0) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and stream outputs.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    mem_read  = mem_read_q;
    mem_addr  = mem_addr_q;
    out_valid = !fifo_empty;
    out_data  = fifo_head;
    push      = vld_q[RD_LAT-1];
    pop       = !fifo_empty && out_ready;
  end

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: a ROM model with one-cycle read latency, a queue scoreboard
// filled from the burst rules, and a negedge monitor that checks issues and output words.
module tb_rom_reader;

  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int NWORD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy;
  logic          done;
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  rom_reader #(
    .AW         (AW),
    .DW         (DW),
    .RD_LAT     (1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  // ROM model: synchronous read, word valid the cycle after the read request.
  logic [DW-1:0] rom [NWORD];
  always @(posedge clk) begin
    if (mem_read) mem_dout <= rom[mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cnt = 0;
  int pop_cnt = 0;
  int issue_base = 0;
  int pop_base = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_issue_cyc = -1;
  int first_valid_cyc = -1;
  int last_pop_cyc = -1;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] ea;
  logic [DW-1:0] ed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues an address or delivers a word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.u_fifo.push) begin
        checks++;
        if (dut.u_fifo.full) begin
          errors++;
          $display("FAIL fifo_overflow: push into full fifo, got full=1, required 0 (cycle %0d)",
                   cyc);
        end
      end
      if (mem_read) begin
        issue_cnt++;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got mem_addr %0d, required no issue (cycle %0d)",
                   mem_addr, cyc);
        end else begin
          ea = exp_addr_q.pop_front();
          if (mem_addr !== ea) begin
            errors++;
            $display("FAIL mem_addr: got %0d, required %0d (cycle %0d)", mem_addr, ea, cyc);
          end
        end
        checks++;
        if ((issue_cnt - issue_base) - (pop_cnt - pop_base) > DEPTH) begin
          errors++;
          $display("FAIL buffered: got %0d outstanding, required at most %0d (cycle %0d)",
                   (issue_cnt - issue_base) - (pop_cnt - pop_base), DEPTH, cyc);
        end
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        last_pop_cyc = cyc;
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %0d, required no word (cycle %0d)", out_data, cyc);
        end else begin
          ed = exp_data_q.pop_front();
          if (out_data !== ed) begin
            errors++;
            $display("FAIL out_data: got %0d, required %0d (cycle %0d)", out_data, ed, cyc);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a burst reads n consecutive addresses modulo 2^AW, in order.
  task automatic expect_burst(input logic [AW-1:0] sa, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = sa + AW'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(rom[a]);
    end
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low for 10 cycles mid-burst.
  task automatic run_burst(input logic [AW-1:0] sa, input int n, input int mode,
                           input bit second);
    int t;
    int d0;
    int bound;
    expect_burst(sa, n);
    first_issue_cyc = -1;
    first_valid_cyc = -1;
    last_pop_cyc    = -1;
    d0              = done_cnt;
    t               = cyc;
    start_addr      = sa;
    count           = (AW + 1)'(n);
    start           = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    bound = 0;
    while (done_cnt == d0 && bound < 300) begin
      case (mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !((cyc - t) >= 5 && (cyc - t) < 15);
        default: out_ready = 1'b1;
      endcase
      if (second && cyc == t + 2) begin
        start      = 1'b1;
        start_addr = sa + AW'(5);
        count      = (AW + 1)'(3);
      end else begin
        start = 1'b0;
      end
      tick();
      bound++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("done_pulses", done_cnt - d0, 1);
    check("words_left", exp_data_q.size(), 0);
    check("addrs_left", exp_addr_q.size(), 0);
    check("done_after_last_pop", done_cyc, last_pop_cyc + 1);
    check("busy_after_done", busy, 0);
    if (mode == 0) begin
      check("first_issue_cycle", first_issue_cyc, t + 1);
      check("first_valid_cycle", first_valid_cyc, t + 3);
      check("pop_span", last_pop_cyc - first_valid_cyc, n - 1);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (4) tick();
    check("single_done", done_cnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int d0;
    int i0;
    int p0;
    int bound;

    for (int i = 0; i < NWORD; i++) rom[i] = DW'($urandom);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    // Basic, wrap-around, back-pressure and ignored-second-start bursts.
    run_burst(AW'(0), 16, 0, 1'b0);
    run_burst(AW'(14), 4, 0, 1'b0);
    run_burst(AW'($urandom), 8, 2, 1'b0);
    run_burst(AW'(3), 10, 0, 1'b1);

    // Zero-length start.
    d0         = done_cnt;
    i0         = issue_cnt;
    t          = cyc;
    start_addr = AW'($urandom);
    count      = '0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("zero_busy", busy, 0);
    tick();
    check("zero_done_cycle", done_cyc, t + 1);
    repeat (3) tick();
    check("zero_done_count", done_cnt - d0, 1);
    check("zero_no_issue", issue_cnt - i0, 0);

    // Randomized bursts with random back-pressure.
    repeat (6) begin
      run_burst(AW'($urandom), $urandom_range(1, 16), 1, 1'b0);
    end

    // Reset after three words have left.
    expect_burst(AW'(5), 16);
    d0         = done_cnt;
    p0         = pop_cnt;
    start_addr = AW'(5);
    count      = (AW + 1)'(16);
    start      = 1'b1;
    tick();
    start = 1'b0;
    bound = 0;
    while (pop_cnt - p0 < 3 && bound < 40) begin
      tick();
      bound++;
    end
    check("pops_before_reset", pop_cnt - p0, 3);
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    tick();
    rst_n      = 1'b1;
    issue_base = issue_cnt;
    pop_base   = pop_cnt;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_mem_read", mem_read, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    repeat (6) tick();
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_burst(AW'(0), 16, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
